// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//   Hardwired control unit for a single-bus CPU datapath. Steps through a
//   three-cycle fetch (T0..T2) followed by one to four execute cycles
//   (T3..T6) chosen by the opcode in IR, and asserts the matching datapath
//   strobes, register enables and ALU select.
//
// Ports
//   Clock      in   rising-edge clock
//   Clear      in   asynchronous active-low reset
//   IR[31:0]   in   latched instruction: opcode[31:27] Ra[26:23] Rb[22:19] Rc[18:15]
//   MemRdy     in   memory read data valid (fetch wait state)
//   Stop       in   halt request, honoured only at instruction end
//   PCout..LOin out datapath strobes
//   Rout/Rin   out  one-hot register-file read/write enables (bit n = Rn)
//   ADD..NOT   out  one-hot ALU operation select
//   Run        out  high while sequencing (not in RST/HALT)
//   IllegalOp  out  sticky undefined-opcode flag, cleared only by Clear
// ---------------------------------------------------------------------------
module control_sequencer (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        MemRdy,
    input  logic        Stop,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic        ADD,
    output logic        SUB,
    output logic        AND,
    output logic        OR,
    output logic        SHR,
    output logic        SHRA,
    output logic        SHL,
    output logic        ROR,
    output logic        ROL,
    output logic        MUL,
    output logic        DIV,
    output logic        NEG,
    output logic        NOT,
    output logic        Run,
    output logic        IllegalOp
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    state_t state, state_nxt;
    logic   illegal_q;

    // IR field extraction
    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign unused_ir = ^IR[14:0];

    // Opcode classes and ALU select, bit order {ADD,SUB,AND,OR,SHR,SHRA,SHL,ROR,ROL,MUL,DIV,NEG,NOT}
    logic        is_two, is_md, is_un, is_halt, is_ill;
    logic [12:0] alu_dec;
    logic [12:0] alu_v;

    always_comb begin
        is_two  = (opcode >= 5'd3) && (opcode <= 5'd11);
        is_md   = (opcode == 5'd15) || (opcode == 5'd16);
        is_un   = (opcode == 5'd17) || (opcode == 5'd18);
        is_halt = (opcode == 5'd27);
        is_ill  = !(is_two || is_md || is_un || is_halt);
        alu_dec = 13'd0;
        case (opcode)
            5'd3:    alu_dec = 13'h1000; // ADD
            5'd4:    alu_dec = 13'h0800; // SUB
            5'd5:    alu_dec = 13'h0400; // AND
            5'd6:    alu_dec = 13'h0200; // OR
            5'd7:    alu_dec = 13'h0020; // ROR
            5'd8:    alu_dec = 13'h0010; // ROL
            5'd9:    alu_dec = 13'h0100; // SHR
            5'd10:   alu_dec = 13'h0080; // SHRA
            5'd11:   alu_dec = 13'h0040; // SHL
            5'd15:   alu_dec = 13'h0008; // MUL
            5'd16:   alu_dec = 13'h0004; // DIV
            5'd17:   alu_dec = 13'h0002; // NEG
            5'd18:   alu_dec = 13'h0001; // NOT
            default: alu_dec = 13'd0;
        endcase
    end

    assign {ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT} = alu_v;
    assign IllegalOp = illegal_q;

    // State register
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) state <= S_RST;
        else        state <= state_nxt;
    end

    // Sticky undefined-opcode flag, raised as T3 is left
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear)                        illegal_q <= 1'b0;
        else if (state == S_T3 && is_ill)  illegal_q <= 1'b1;
    end

    // Next-state logic
    state_t end_nxt;
    always_comb begin
        end_nxt   = Stop ? S_HALT : S_T0;
        state_nxt = state;
        case (state)
            S_RST:  state_nxt = S_T0;
            S_T0:   state_nxt = S_T1;
            S_T1:   state_nxt = MemRdy ? S_T2 : S_T1;
            S_T2:   state_nxt = S_T3;
            S_T3: begin
                if (is_halt)     state_nxt = S_HALT;
                else if (is_ill) state_nxt = S_T0;   // NOP; Stop not honoured here
                else             state_nxt = S_T4;
            end
            S_T4:   state_nxt = is_un ? end_nxt : (is_ill || is_halt) ? S_T0 : S_T5;
            S_T5:   state_nxt = is_md ? S_T6 : (is_two ? end_nxt : S_T0);
            S_T6:   state_nxt = end_nxt;
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_RST;
        endcase
    end

    // Output decode. PCin is the one term qualified by an input: it must
    // fire only in the T1 cycle that actually leaves T1, so PC loads once
    // no matter how many wait cycles memory inserts.
    always_comb begin
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; Read = 1'b0; IRin = 1'b0;
        Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0;
        HIin = 1'b0; LOin = 1'b0;
        Rout = 16'd0; Rin = 16'd0; alu_v = 13'd0; Run = 1'b0;
        case (state)
            S_T0: begin
                Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            S_T1: begin
                Run = 1'b1; Zlowout = 1'b1; Read = 1'b1; MDRin = 1'b1; PCin = MemRdy;
            end
            S_T2: begin
                Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                Run = 1'b1;
                if (is_two) begin
                    Rout = 16'd1 << rb; Yin = 1'b1;
                end else if (is_md) begin
                    Rout = 16'd1 << ra; Yin = 1'b1;
                end else if (is_un) begin
                    Rout = 16'd1 << rb; alu_v = alu_dec; Zin = 1'b1;
                end
            end
            S_T4: begin
                Run = 1'b1;
                if (is_two) begin
                    Rout = 16'd1 << rc; alu_v = alu_dec; Zin = 1'b1;
                end else if (is_md) begin
                    Rout = 16'd1 << rb; alu_v = alu_dec; Zin = 1'b1;
                end else if (is_un) begin
                    Zlowout = 1'b1; Rin = 16'd1 << ra;
                end
            end
            S_T5: begin
                Run = 1'b1;
                if (is_two) begin
                    Zlowout = 1'b1; Rin = 16'd1 << ra;
                end else if (is_md) begin
                    Zlowout = 1'b1; LOin = 1'b1;
                end
            end
            S_T6: begin
                Run = 1'b1;
                if (is_md) begin
                    Zhighout = 1'b1; HIin = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Clear = 1'b0;
    logic [31:0] IR = 32'd0;
    logic        MemRdy = 1'b1;
    logic        Stop = 1'b0;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin;
    logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin;
    logic [15:0] Rout, Rin;
    logic        ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT;
    logic        Run, IllegalOp;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    control_sequencer dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .MemRdy(MemRdy), .Stop(Stop),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .Read(Read), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
        .Rout(Rout), .Rin(Rin),
        .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .SHR(SHR), .SHRA(SHRA),
        .SHL(SHL), .ROR(ROR), .ROL(ROL), .MUL(MUL), .DIV(DIV), .NEG(NEG), .NOT(NOT),
        .Run(Run), .IllegalOp(IllegalOp)
    );

    // strobe bits {PCout,PCin,IncPC,MARin,MDRin,MDRout,Read,IRin,Yin,Zin,Zlowout,Zhighout,HIin,LOin}
    localparam logic [13:0] S_PCOUT = 14'h2000, S_PCIN = 14'h1000, S_INCPC = 14'h0800,
                            S_MARIN = 14'h0400, S_MDRIN = 14'h0200, S_MDROUT = 14'h0100,
                            S_READ = 14'h0080, S_IRIN = 14'h0040, S_YIN = 14'h0020,
                            S_ZIN = 14'h0010, S_ZLOW = 14'h0008, S_ZHIGH = 14'h0004,
                            S_HIIN = 14'h0002, S_LOIN = 14'h0001;
    // ALU bits {ADD,SUB,AND,OR,SHR,SHRA,SHL,ROR,ROL,MUL,DIV,NEG,NOT}
    localparam logic [12:0] A_ADD = 13'h1000, A_SHL = 13'h0040, A_MUL = 13'h0008,
                            A_NEG = 13'h0002, A_NOT = 13'h0001;

    function automatic logic [60:0] obs();
        return {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin,
                Zlowout, Zhighout, HIin, LOin,
                ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT,
                Rout, Rin, Run, IllegalOp};
    endfunction

    function automatic logic [60:0] mk(logic [13:0] s, logic [12:0] a, logic [15:0] ro,
                                       logic [15:0] ri, logic run, logic ill);
        return {s, a, ro, ri, run, ill};
    endfunction

    function automatic logic [60:0] e_t0(logic ill);
        return mk(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 13'd0, 16'd0, 16'd0, 1'b1, ill);
    endfunction
    function automatic logic [60:0] e_t1(logic ill);
        return mk(S_ZLOW | S_PCIN | S_READ | S_MDRIN, 13'd0, 16'd0, 16'd0, 1'b1, ill);
    endfunction
    function automatic logic [60:0] e_t2(logic ill);
        return mk(S_MDROUT | S_IRIN, 13'd0, 16'd0, 16'd0, 1'b1, ill);
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Leaves the sequencer freshly in T0
    task automatic apply_reset();
        @(negedge Clock);
        Clear = 1'b0;
        #2;
        Clear = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        Clear = 1'b0; MemRdy = 1'b1; Stop = 1'b0; IR = 32'd0;
        #3;
        checks++;
        if (obs() !== 61'd0) begin errors++; $display("FAIL reset_async got %h want %h", obs(), 61'd0); end
        tick();
        checks++;
        if (obs() !== 61'd0) begin errors++; $display("FAIL reset_held got %h want %h", obs(), 61'd0); end
        @(negedge Clock);
        Clear = 1'b1;
        #1;
        checks++;
        if (obs() !== 61'd0) begin errors++; $display("FAIL reset_release got %h want %h", obs(), 61'd0); end
        tick();
        checks++;
        if (obs() !== e_t0(1'b0)) begin errors++; $display("FAIL reset_first_t0 got %h want %h", obs(), e_t0(1'b0)); end
    endtask

    task automatic test_shl();
        logic [60:0] e [0:6];
        IR = 32'h58918000; // SHL R1,R2,R3
        e[0] = e_t0(1'b0); e[1] = e_t1(1'b0); e[2] = e_t2(1'b0);
        e[3] = mk(S_YIN, 13'd0, 16'h0004, 16'd0, 1'b1, 1'b0);
        e[4] = mk(S_ZIN, A_SHL, 16'h0008, 16'd0, 1'b1, 1'b0);
        e[5] = mk(S_ZLOW, 13'd0, 16'd0, 16'h0002, 1'b1, 1'b0);
        e[6] = e_t0(1'b0);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            checks++;
            if (obs() !== e[i]) begin errors++; $display("FAIL shl cyc %0d got %h want %h", i, obs(), e[i]); end
        end
    endtask

    task automatic test_mul();
        logic [60:0] e [0:7];
        IR = 32'h7A280000; // MUL R4,R5
        e[0] = e_t0(1'b0); e[1] = e_t1(1'b0); e[2] = e_t2(1'b0);
        e[3] = mk(S_YIN, 13'd0, 16'h0010, 16'd0, 1'b1, 1'b0);
        e[4] = mk(S_ZIN, A_MUL, 16'h0020, 16'd0, 1'b1, 1'b0);
        e[5] = mk(S_ZLOW | S_LOIN, 13'd0, 16'd0, 16'd0, 1'b1, 1'b0);
        e[6] = mk(S_ZHIGH | S_HIIN, 13'd0, 16'd0, 16'd0, 1'b1, 1'b0);
        e[7] = e_t0(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            checks++;
            if (obs() !== e[i]) begin errors++; $display("FAIL mul cyc %0d got %h want %h", i, obs(), e[i]); end
        end
    endtask

    task automatic test_back_to_back_neg();
        logic [60:0] e [0:5];
        IR = 32'h8B380000; // NEG R6,R7
        e[0] = e_t0(1'b0); e[1] = e_t1(1'b0); e[2] = e_t2(1'b0);
        e[3] = mk(S_ZIN, A_NEG, 16'h0080, 16'd0, 1'b1, 1'b0);
        e[4] = mk(S_ZLOW, 13'd0, 16'd0, 16'h0040, 1'b1, 1'b0);
        e[5] = e_t0(1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            checks++;
            if (obs() !== e[i]) begin errors++; $display("FAIL neg cyc %0d got %h want %h", i, obs(), e[i]); end
        end
    endtask

    task automatic test_mem_wait();
        logic [60:0] t1_wait, e [0:3];
        IR = 32'h90900000; // NOT R1,R2
        t1_wait = mk(S_ZLOW | S_READ | S_MDRIN, 13'd0, 16'd0, 16'd0, 1'b1, 1'b0);
        MemRdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs() !== t1_wait) begin errors++; $display("FAIL memwait cyc %0d got %h want %h", i, obs(), t1_wait); end
        end
        tick();
        MemRdy = 1'b1;
        #1;
        checks++;
        if (obs() !== e_t1(1'b0)) begin errors++; $display("FAIL memwait_exit got %h want %h", obs(), e_t1(1'b0)); end
        e[0] = e_t2(1'b0);
        e[1] = mk(S_ZIN, A_NOT, 16'h0004, 16'd0, 1'b1, 1'b0);
        e[2] = mk(S_ZLOW, 13'd0, 16'd0, 16'h0002, 1'b1, 1'b0);
        e[3] = e_t0(1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs() !== e[i]) begin errors++; $display("FAIL not cyc %0d got %h want %h", i, obs(), e[i]); end
        end
    endtask

    task automatic test_stop();
        logic [60:0] t3, t4, t5;
        IR = 32'h18918000; // ADD R1,R2,R3
        t3 = mk(S_YIN, 13'd0, 16'h0004, 16'd0, 1'b1, 1'b0);
        t4 = mk(S_ZIN, A_ADD, 16'h0008, 16'd0, 1'b1, 1'b0);
        t5 = mk(S_ZLOW, 13'd0, 16'd0, 16'h0002, 1'b1, 1'b0);
        tick(); tick(); tick();
        checks++;
        if (obs() !== t3) begin errors++; $display("FAIL add_t3 got %h want %h", obs(), t3); end
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        checks++;
        if (obs() !== t4) begin errors++; $display("FAIL stop_in_t3_ignored got %h want %h", obs(), t4); end
        tick();
        checks++;
        if (obs() !== t5) begin errors++; $display("FAIL add_t5 got %h want %h", obs(), t5); end
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        checks++;
        if (obs() !== 61'd0) begin errors++; $display("FAIL stop_halt got %h want %h", obs(), 61'd0); end
        tick(); tick();
        checks++;
        if (obs() !== 61'd0) begin errors++; $display("FAIL halt_absorbing got %h want %h", obs(), 61'd0); end
    endtask

    task automatic test_halt_op();
        logic [60:0] e [0:5];
        apply_reset();
        IR = 32'hD8000000;
        e[0] = e_t0(1'b0); e[1] = e_t1(1'b0); e[2] = e_t2(1'b0);
        e[3] = mk(14'd0, 13'd0, 16'd0, 16'd0, 1'b1, 1'b0);
        e[4] = 61'd0;
        e[5] = 61'd0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            checks++;
            if (obs() !== e[i]) begin errors++; $display("FAIL halt_op cyc %0d got %h want %h", i, obs(), e[i]); end
        end
    endtask

    task automatic test_illegal();
        logic [60:0] e [0:8];
        apply_reset();
        IR = 32'hF8000000;
        e[0] = e_t0(1'b0); e[1] = e_t1(1'b0); e[2] = e_t2(1'b0);
        e[3] = mk(14'd0, 13'd0, 16'd0, 16'd0, 1'b1, 1'b0);
        e[4] = e_t0(1'b1);
        e[5] = e_t1(1'b1); e[6] = e_t2(1'b1);
        e[7] = mk(S_YIN, 13'd0, 16'h0004, 16'd0, 1'b1, 1'b1);
        e[8] = mk(S_ZIN, A_SHL, 16'h0008, 16'd0, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) tick();
            if (i == 4) IR = 32'h58918000;
            checks++;
            if (obs() !== e[i]) begin errors++; $display("FAIL illegal cyc %0d got %h want %h", i, obs(), e[i]); end
        end
        #2;
        Clear = 1'b0;
        #1;
        checks++;
        if (obs() !== 61'd0) begin errors++; $display("FAIL clear_mid_t4 got %h want %h", obs(), 61'd0); end
        tick();
        checks++;
        if (obs() !== 61'd0) begin errors++; $display("FAIL clear_held got %h want %h", obs(), 61'd0); end
        @(negedge Clock);
        Clear = 1'b1;
        tick();
        checks++;
        if (obs() !== e_t0(1'b0)) begin errors++; $display("FAIL clear_restart got %h want %h", obs(), e_t0(1'b0)); end
    endtask

    initial begin
        test_reset();
        test_shl();
        test_mul();
        test_back_to_back_neg();
        test_mem_wait();
        test_stop();
        test_halt_op();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
